// File: rtl/alu_result_demux.sv
// Routes a tagged ALU result stream to one of NCH consumer channels through a
// 2-entry in-order FIFO; out-of-range destination codes are dropped and counted.
module alu_result_demux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_ctl,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic [7:0]       drop_count,
  input  logic             err_clr,
  output logic             busy
);

  localparam logic [4:0] NCH_LIM  = 5'(NCH);
  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [3:0]       mem_ctl  [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic             full;
  logic             empty;
  logic             legal;
  logic             accept;
  logic             push;
  logic             drop;
  logic             pop;
  logic [3:0]       head_ctl;
  logic [WIDTH-1:0] head_data;
  logic [7:0]       drop_base;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign busy      = !empty;
  assign head_ctl  = mem_ctl[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign out_data  = empty ? '0 : head_data;

  assign legal  = ({1'b0, in_ctl} < NCH_LIM);
  assign accept = in_valid && !full;
  assign push   = accept && legal;
  assign drop   = accept && !legal;

  always_comb begin
    out_valid = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      out_valid[i] = !empty && (head_ctl == 4'(i));
    end
  end

  // Only the head channel's ready bit can survive the mask, so this is the pop.
  assign pop = |(out_valid & out_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_ctl[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= in_data;
        mem_ctl[wr_ptr]  <= in_ctl;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A clear and a drop in the same cycle count from zero, giving a count of one.
  assign drop_base = err_clr ? '0 : drop_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err        <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      err        <= 1'b1;
      drop_count <= (drop_base == 8'hFF) ? drop_base : drop_base + 8'd1;
    end else if (err_clr) begin
      err        <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_alu_result_demux.sv
// Bench for alu_result_demux: table-driven vectors, hand sequences for the
// multi-cycle cases, and a queue scoreboard checking every cycle.
module tb_alu_result_demux;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_ctl;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic [31:0] out_data;
  logic        err;
  logic [7:0]  drop_count;
  logic        err_clr;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  alu_result_demux #(.WIDTH(32), .NCH(5), .DEPTH(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctl     (in_ctl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err        (err),
    .drop_count (drop_count),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: queue of accepted legal entries plus error state.
  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
  } ent_t;

  ent_t       exp_q[$];
  logic       m_err  = 1'b0;
  logic [7:0] m_drop = '0;

  always @(negedge clk) begin
    logic [4:0]  e_ov;
    logic [31:0] e_od;
    logic        m_ir;
    logic        acc;
    if (!reset_n) begin
      exp_q.delete();
      m_err  = 1'b0;
      m_drop = '0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_data", out_data, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
    end else begin
      e_ov = '0;
      e_od = '0;
      if (exp_q.size() != 0) begin
        e_ov = 5'b00001 << exp_q[0].c;
        e_od = exp_q[0].d;
      end
      m_ir = (exp_q.size() < 2);
      check("sb_out_valid", 32'(out_valid), 32'(e_ov));
      check("sb_out_data", out_data, e_od);
      check("sb_in_ready", 32'(in_ready), 32'(m_ir));
      check("sb_busy", 32'(busy), 32'(exp_q.size() != 0));
      check("sb_err", 32'(err), 32'(m_err));
      check("sb_drop", 32'(drop_count), 32'(m_drop));
      if (exp_q.size() != 0 && (out_ready & e_ov) != 5'd0) begin
        void'(exp_q.pop_front());
        pops++;
      end
      acc = in_valid && m_ir;
      if (acc && in_ctl < 4'd5) exp_q.push_back('{d: in_data, c: in_ctl});
      if (err_clr) begin
        m_err  = 1'b0;
        m_drop = '0;
      end
      if (acc && in_ctl >= 4'd5) begin
        m_err = 1'b1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] d,
                       input logic [4:0] r, input logic clr);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_ctl    = c;
    in_data   = d;
    out_ready = r;
    err_clr   = clr;
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  ctl;
    logic [31:0] data;
    logic [4:0]  rdy;
    logic        clr;
    logic [4:0]  e_ov;
    logic        e_ir;
    logic        e_busy;
    logic        e_err;
    logic [7:0]  e_drop;
    logic [31:0] e_od;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [3:0] ctl, input logic [31:0] data,
                              input logic [4:0] rdy, input logic clr, input logic [4:0] e_ov,
                              input logic e_ir, input logic e_busy, input logic e_err,
                              input logic [7:0] e_drop, input logic [31:0] e_od);
    mk = '{v, ctl, data, rdy, clr, e_ov, e_ir, e_busy, e_err, e_drop, e_od};
  endfunction

  vec_t tbl[16];

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Expected fields describe outputs during the cycle the row's inputs are driven.
    tbl[0]  = mk(1, 3,  32'hDEADBEEF, 5'b01000, 0, 5'b00000, 1, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0,  32'h0,        5'b01000, 0, 5'b01000, 1, 1, 0, 0, 32'hDEADBEEF);
    tbl[2]  = mk(0, 0,  32'h0,        5'b00000, 0, 5'b00000, 1, 0, 0, 0, 32'h0);
    tbl[3]  = mk(1, 0,  32'hA0A0A0A0, 5'b00000, 0, 5'b00000, 1, 0, 0, 0, 32'h0);
    tbl[4]  = mk(1, 4,  32'hA4A4A4A4, 5'b00000, 0, 5'b00001, 1, 1, 0, 0, 32'hA0A0A0A0);
    tbl[5]  = mk(0, 0,  32'h0,        5'b00001, 0, 5'b00001, 0, 1, 0, 0, 32'hA0A0A0A0);
    tbl[6]  = mk(0, 0,  32'h0,        5'b00000, 0, 5'b10000, 1, 1, 0, 0, 32'hA4A4A4A4);
    tbl[7]  = mk(0, 0,  32'h0,        5'b10000, 0, 5'b10000, 1, 1, 0, 0, 32'hA4A4A4A4);
    tbl[8]  = mk(0, 0,  32'h0,        5'b00000, 0, 5'b00000, 1, 0, 0, 0, 32'h0);
    tbl[9]  = mk(1, 5,  32'hC5C5C5C5, 5'b00000, 0, 5'b00000, 1, 0, 0, 0, 32'h0);
    tbl[10] = mk(1, 15, 32'hCFCFCFCF, 5'b00000, 0, 5'b00000, 1, 0, 1, 1, 32'h0);
    tbl[11] = mk(1, 0,  32'hC0C0C0C0, 5'b00000, 0, 5'b00000, 1, 0, 1, 2, 32'h0);
    tbl[12] = mk(1, 7,  32'hC7C7C7C7, 5'b00001, 1, 5'b00001, 1, 1, 1, 2, 32'hC0C0C0C0);
    tbl[13] = mk(0, 0,  32'h0,        5'b00000, 0, 5'b00000, 1, 0, 1, 1, 32'h0);
    tbl[14] = mk(0, 0,  32'h0,        5'b00000, 1, 5'b00000, 1, 0, 1, 1, 32'h0);
    tbl[15] = mk(0, 0,  32'h0,        5'b00000, 0, 5'b00000, 1, 0, 0, 0, 32'h0);

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_ctl    = '0;
    in_data   = '0;
    out_ready = '0;
    err_clr   = 1'b0;
    #3;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].ctl, tbl[i].data, tbl[i].rdy, tbl[i].clr);
      @(negedge clk);
      check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      check($sformatf("tbl%0d_drop", i), 32'(drop_count), 32'(tbl[i].e_drop));
      check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
    end

    // Head-of-line blocking: ch1 at head stalls ch2 even though ch2 is ready.
    drive(1, 1, 32'hB1B1B1B1, 5'b00100, 0);
    drive(1, 2, 32'hB2B2B2B2, 5'b00100, 0);
    drive(0, 0, 32'h0, 5'b00100, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hol_stall_valid", 32'(out_valid), 32'h02);
      check("hol_stall_full", 32'(in_ready), 32'd0);
    end
    drive(0, 0, 32'h0, 5'b00110, 0);
    @(negedge clk);
    check("hol_pre_pop", 32'(out_valid), 32'h02);
    @(negedge clk);
    check("hol_ch2_valid", 32'(out_valid), 32'h04);
    check("hol_ch2_data", out_data, 32'hB2B2B2B2);
    @(negedge clk);
    check("hol_drained", 32'(busy), 32'd0);
    drive(0, 0, 32'h0, 5'b00000, 0);

    // Streaming: one result per cycle alternating ch0/ch2.
    begin
      int pops_before;
      pops_before = pops;
      for (int i = 0; i < 300; i++) begin
        drive(1, (i % 2 == 1) ? 4'd2 : 4'd0, 32'h1000_0000 + 32'(i), 5'b00101, 0);
      end
      drive(0, 0, 32'h0, 5'b00101, 0);
      @(negedge clk);
      check("stream_last_busy", 32'(busy), 32'd1);
      check("stream_last_data", out_data, 32'h1000_012B);
      @(negedge clk);
      check("stream_drained", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("stream_pop_count", 32'(pops - pops_before), 32'd300);
      check("stream_no_drops", 32'(drop_count), 32'd0);
    end

    // Saturating drop counter.
    for (int i = 0; i < 260; i++) drive(1, 4'd9, 32'(i), 5'b00000, 0);
    drive(0, 0, 32'h0, 5'b00000, 0);
    @(negedge clk);
    check("sat_drop", 32'(drop_count), 32'd255);
    check("sat_err", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) drive(1, 4'd12, 32'h0, 5'b00000, 0);
    drive(0, 0, 32'h0, 5'b00000, 0);
    @(negedge clk);
    check("sat_hold", 32'(drop_count), 32'd255);
    check("sat_busy", 32'(busy), 32'd0);

    // Reset while full, between clock edges.
    drive(1, 0, 32'hD0D0D0D0, 5'b00000, 0);
    drive(1, 4, 32'hD4D4D4D4, 5'b00000, 0);
    drive(0, 0, 32'h0, 5'b00000, 0);
    check("midrst_full", 32'(in_ready), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_drop", 32'(drop_count), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_no_stale", 32'(out_valid), 32'd0);
    end
    drive(1, 2, 32'hE2E2E2E2, 5'b00100, 0);
    drive(0, 0, 32'h0, 5'b00100, 0);
    @(negedge clk);
    check("postrst_valid", 32'(out_valid), 32'h04);
    check("postrst_data", out_data, 32'hE2E2E2E2);
    @(negedge clk);
    check("postrst_drained", 32'(busy), 32'd0);
    drive(0, 0, 32'h0, 5'b00000, 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
